// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port.
// Round-robin grant, one transaction in flight, response timeout with sticky error.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);
   localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);
   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_grant;
   logic              r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_wmask;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic              r_ifu_resp_valid;
   logic              r_lsu_resp_valid;
   logic [DATA_W-1:0] r_ifu_rdata;
   logic [DATA_W-1:0] r_lsu_rdata;

   logic              w_grant_lsu;
   logic              w_ifu_ready;
   logic              w_lsu_ready;
   logic              w_accept;
   logic              w_resp;
   logic              w_abort;
   logic [DATA_W-1:0] w_resp_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // LSU wins a tie only when IFU held the previous grant.
   always_comb begin
      w_state_nxt = r_state;
      w_ifu_ready = 1'b0;
      w_lsu_ready = 1'b0;
      w_accept    = 1'b0;
      w_resp      = 1'b0;
      w_abort     = 1'b0;
      w_grant_lsu = lsu_req_valid & (~ifu_req_valid | (r_last_grant == OWN_IFU));
      case (r_state)
         S_IDLE: begin
            w_ifu_ready = ifu_req_valid & ~w_grant_lsu;
            w_lsu_ready = w_grant_lsu;
            w_accept    = ifu_req_valid | lsu_req_valid;
            if (w_accept) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               w_resp      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_LIMIT) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_resp_data = w_resp ? mem_rdata : ABORT_DATA;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant     <= OWN_LSU;
         r_owner          <= OWN_IFU;
         r_addr           <= '0;
         r_wen            <= 1'b0;
         r_wdata          <= '0;
         r_wmask          <= 8'h00;
         r_cnt            <= '0;
         r_err            <= 1'b0;
         r_ifu_resp_valid <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_ifu_rdata      <= '0;
         r_lsu_rdata      <= '0;
      end else begin
         r_ifu_resp_valid <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         // Fetches are always reads, so store fields are forced to zero.
         if (w_accept) begin
            r_owner      <= w_grant_lsu;
            r_last_grant <= w_grant_lsu;
            r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
            r_wen        <= w_grant_lsu & lsu_wen;
            r_wdata      <= w_grant_lsu ? lsu_wdata : '0;
            r_wmask      <= w_grant_lsu ? lsu_wmask : 8'h00;
         end
         if (r_state == S_REQ && mem_req_ready) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT && !w_abort) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_resp || w_abort) begin
            if (r_owner == OWN_LSU) begin
               r_lsu_resp_valid <= 1'b1;
               r_lsu_rdata      <= w_resp_data;
            end else begin
               r_ifu_resp_valid <= 1'b1;
               r_ifu_rdata      <= w_resp_data;
            end
         end
         if (w_abort || (mem_resp_valid && r_state != S_WAIT)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign ifu_req_ready  = w_ifu_ready;
   assign lsu_req_ready  = w_lsu_ready;
   assign ifu_resp_valid = r_ifu_resp_valid;
   assign lsu_resp_valid = r_lsu_resp_valid;
   assign ifu_rdata      = r_ifu_rdata;
   assign lsu_rdata      = r_lsu_rdata;
   assign mem_req_valid  = (r_state == S_REQ);
   assign mem_addr       = r_addr;
   assign mem_wen        = r_wen;
   assign mem_wdata      = r_wdata;
   assign mem_wmask      = r_wmask;
   assign err            = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, round-robin, stalled store,
// timeout abort, spurious response and reset during an outstanding transaction.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ifu_req_valid = 1'b0;
   logic          ifu_req_ready;
   logic [AW-1:0] ifu_addr = '0;
   logic          ifu_resp_valid;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid = 1'b0;
   logic          lsu_req_ready;
   logic [AW-1:0] lsu_addr = '0;
   logic          lsu_wen = 1'b0;
   logic [DW-1:0] lsu_wdata = '0;
   logic [7:0]    lsu_wmask = 8'h00;
   logic          lsu_resp_valid;
   logic [DW-1:0] lsu_rdata;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [7:0]    mem_wmask;
   logic          mem_resp_valid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          err;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = 8'h00;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
      n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
      n_vec++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== 73'd0) begin n_err++; $display("FAIL reset_mem_fields: got %h want 0", {mem_addr, mem_wdata, mem_wmask, mem_wen}); end
      n_vec++; if ({ifu_rdata, lsu_rdata} !== 64'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {ifu_rdata, lsu_rdata}); end
      n_vec++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_err++; $display("FAIL reset_idle_ready: got %b want 00", {ifu_req_ready, lsu_req_ready}); end
   endtask

   task automatic test_ifu_read();
      // cycle 0: accept
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
      #1;
      n_vec++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_err++; $display("FAIL rd_ready: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
      step();
      // cycle 1: REQ, ready already high
      ifu_req_valid = 1'b0; ifu_addr = 32'h0BAD_0BAD;
      #1;
      n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rd_mem_req_valid: got %b want 1", mem_req_valid); end
      n_vec++; if (mem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL rd_mem_addr: got %h want 80000000", mem_addr); end
      n_vec++; if ({mem_wen, mem_wmask, mem_wdata} !== 41'd0) begin n_err++; $display("FAIL rd_store_fields: got %h want 0", {mem_wen, mem_wmask, mem_wdata}); end
      step();
      // cycle 2: WAIT, response arrives
      mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0013;
      n_vec++; if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin n_err++; $display("FAIL rd_wait_outputs: got %b want 00", {mem_req_valid, ifu_resp_valid}); end
      step();
      // cycle 3: response pulse
      mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      n_vec++; if (ifu_resp_valid !== 1'b1) begin n_err++; $display("FAIL rd_ifu_resp_valid: got %b want 1", ifu_resp_valid); end
      n_vec++; if (ifu_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL rd_ifu_rdata: got %h want 00000013", ifu_rdata); end
      n_vec++; if (lsu_resp_valid !== 1'b0) begin n_err++; $display("FAIL rd_lsu_resp_valid: got %b want 0", lsu_resp_valid); end
      step();
      n_vec++; if (ifu_resp_valid !== 1'b0) begin n_err++; $display("FAIL rd_pulse_width: got %b want 0", ifu_resp_valid); end
      n_vec++; if (ifu_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL rd_rdata_hold: got %h want 00000013", ifu_rdata); end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic own;
      logic [DW-1:0] rd;
      do_reset();
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
      lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_wen = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         own = k[0];
         rd = 32'h0000_00A0 + 32'(k);
         n_vec++; if ({ifu_req_ready, lsu_req_ready} !== {~own, own}) begin n_err++; $display("FAIL b2b_grant%0d: got %b want %b", k, {ifu_req_ready, lsu_req_ready}, {~own, own}); end
         step();
         n_vec++; if (mem_addr !== (own ? 32'h0000_2000 : 32'h0000_1000)) begin n_err++; $display("FAIL b2b_addr%0d: got %h want %h", k, mem_addr, (own ? 32'h0000_2000 : 32'h0000_1000)); end
         step();
         mem_resp_valid = 1'b1; mem_rdata = rd;
         step();
         mem_resp_valid = 1'b0;
         #1;
         n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== {~own, own}) begin n_err++; $display("FAIL b2b_resp%0d: got %b want %b", k, {ifu_resp_valid, lsu_resp_valid}, {~own, own}); end
         n_vec++; if ((own ? lsu_rdata : ifu_rdata) !== rd) begin n_err++; $display("FAIL b2b_rdata%0d: got %h want %h", k, (own ? lsu_rdata : ifu_rdata), rd); end
      end
      clear_inputs();
      step();
   endtask

   task automatic test_store_stall();
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
      lsu_wdata = 32'h1234_5678; lsu_wmask = 8'h0F; mem_req_ready = 1'b0;
      #1;
      n_vec++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin n_err++; $display("FAIL st_ready: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
      step();
      // requester withdraws and scribbles its fields; the latched copy must not move
      lsu_req_valid = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h0; lsu_wmask = 8'hF0; lsu_wen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mem_req_ready = (i == 5);
         #1;
         n_vec++; if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, 32'h8000_0100, 32'h1234_5678, 8'h0F}) begin
            n_err++; $display("FAIL st_req_hold%0d: got %h want %h", i, {mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask}, {1'b1, 1'b1, 32'h8000_0100, 32'h1234_5678, 8'h0F});
         end
         step();
      end
      mem_req_ready = 1'b0;
      n_vec++; if ({mem_req_valid, lsu_resp_valid} !== 2'b00) begin n_err++; $display("FAIL st_wait: got %b want 00", {mem_req_valid, lsu_resp_valid}); end
      step();
      step();
      mem_resp_valid = 1'b1; mem_rdata = 32'hAAAA_5555;
      step();
      mem_resp_valid = 1'b0;
      n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b01) begin n_err++; $display("FAIL st_resp: got %b want 01", {ifu_resp_valid, lsu_resp_valid}); end
      n_vec++; if (lsu_rdata !== 32'hAAAA_5555) begin n_err++; $display("FAIL st_rdata: got %h want aaaa5555", lsu_rdata); end
      step();
      n_vec++; if (lsu_resp_valid !== 1'b0) begin n_err++; $display("FAIL st_pulse_width: got %b want 0", lsu_resp_valid); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL st_no_err: got %b want 0", err); end
      clear_inputs();
   endtask

   task automatic test_timeout();
      int  n;
      logic got;
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_4000; mem_req_ready = 1'b1;
      step();
      ifu_req_valid = 1'b0;
      step();
      mem_req_ready = 1'b0;
      // now in the first WAIT cycle
      n = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (ifu_resp_valid === 1'b1) got = 1'b1;
         else begin step(); n++; end
      end
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL to_pulse: got none want pulse within 20 cycles"); end
      n_vec++; if (n < TO || n > TO + 1) begin n_err++; $display("FAIL to_latency: got %0d want %0d..%0d cycles after WAIT entry", n, TO, TO + 1); end
      n_vec++; if (ifu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL to_rdata: got %h want deadbeef", ifu_rdata); end
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", err); end
      n_vec++; if (lsu_resp_valid !== 1'b0) begin n_err++; $display("FAIL to_lsu_quiet: got %b want 0", lsu_resp_valid); end
      step();
      step();
      n_vec++; if ({err, ifu_resp_valid} !== 2'b10) begin n_err++; $display("FAIL to_err_sticky: got %b want 10", {err, ifu_resp_valid}); end
      clear_inputs();
   endtask

   task automatic test_spurious_resp();
      do_reset();
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL sp_err_cleared: got %b want 0", err); end
      mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
      step();
      mem_resp_valid = 1'b0;
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL sp_err: got %b want 1", err); end
      n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_err++; $display("FAIL sp_no_pulse: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      n_vec++; if ({ifu_rdata, lsu_rdata} !== 64'd0) begin n_err++; $display("FAIL sp_rdata: got %h want 0", {ifu_rdata, lsu_rdata}); end
      step();
      n_vec++; if ({err, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin n_err++; $display("FAIL sp_after: got %b want 100", {err, ifu_resp_valid, lsu_resp_valid}); end
   endtask

   task automatic test_reset_in_wait();
      ifu_req_valid = 1'b1; ifu_addr = 32'h0000_7000; mem_req_ready = 1'b1;
      step();
      ifu_req_valid = 1'b0;
      step();
      mem_req_ready = 1'b0;
      // in WAIT: assert reset between clock edges
      #2;
      rst = 1'b0;
      #1;
      n_vec++; if ({mem_req_valid, mem_wen, ifu_resp_valid, lsu_resp_valid, err} !== 5'b00000) begin n_err++; $display("FAIL rw_ctrl: got %b want 00000", {mem_req_valid, mem_wen, ifu_resp_valid, lsu_resp_valid, err}); end
      n_vec++; if ({mem_addr, mem_wdata, mem_wmask} !== 72'd0) begin n_err++; $display("FAIL rw_mem_fields: got %h want 0", {mem_addr, mem_wdata, mem_wmask}); end
      step();
      rst = 1'b1;
      step();
      mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
      step();
      mem_resp_valid = 1'b0;
      n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_err++; $display("FAIL rw_no_pulse: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      n_vec++; if (ifu_rdata !== 32'd0) begin n_err++; $display("FAIL rw_rdata: got %h want 0", ifu_rdata); end
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL rw_spurious_err: got %b want 1", err); end
      step();
      n_vec++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_err++; $display("FAIL rw_no_pulse_late: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      #1;
      n_vec++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_err++; $display("FAIL rw_tie_ifu: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
      clear_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_ifu_read();
      test_back_to_back();
      test_store_stall();
      test_timeout();
      test_spurious_resp();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
